mult_arbiter: RTL
=================

Name: mult_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one Multiplicator instance between N_REQ requesters.
- Each requester submits operand pairs through a request/grant handshake. The arbiter latches the winning operands and drives the multiplier's iValid_Data/iAcknoledged handshake.
- It returns each product on a shared result bus, tagged with the owner's ID.
- Includes a watchdog that aborts a job if the multiplier never signals done.

Parameters:
- N_REQ, 4, number of requesters (2..8); IDW = clog2(N_REQ) is a derived localparam.
- WIDTH, 32, operand and result width; must match the multiplier.
- TIMEOUT, 64, maximum cycles in WAIT before the job is aborted.

Ports:
- Clock  in  1  system clock; one clock domain.
- Reset  in  1  one clock; reset is asynchronous and active-low.
- iReq  in  N_REQ  per-requester request; held with operands stable until the matching oGrant bit.
- iData_A  in  N_REQ*WIDTH  flattened operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- iData_B  in  N_REQ*WIDTH  flattened operand B; same packing as iData_A.
- oGrant  out  N_REQ  one-cycle one-hot pulse: operands of requester i captured.
- oResult  out  WIDTH  last product; held until the next completion.
- oResultValid  out  1  one-cycle pulse when oResult/oResultId update.
- oResultId  out  IDW  owner of oResult.
- oError  out  1  one-cycle pulse on watchdog abort.
- oErrorId  out  IDW  owner of the aborted job.
- oBusy  out  1  high whenever state != IDLE.
- oMult_A  out  WIDTH  to multiplier iData_A; held from grant until return to IDLE.
- oMult_B  out  WIDTH  to multiplier iData_B; same hold rule.
- oMult_Valid  out  1  to multiplier iValid_Data.
- oMult_Ack  out  1  to multiplier iAcknoledged.
- iMult_Done  in  1  from multiplier oDone.
- iMult_Idle  in  1  from multiplier oIdle.
- iMult_Result  in  WIDTH  from multiplier oResult.

Behaviour:
- All outputs are registered.
- Reset asserted (Reset=0), asynchronous: state=IDLE; round-robin pointer=0; watchdog=0; owner=0; all outputs 0 (oResult=0, oMult_A/B=0).
- Reset mid-job discards the job silently; no oResultValid, no oError.
- FSM states: IDLE, ISSUE, WAIT, DRAIN.
- IDLE:
  - Transition condition: |iReq && iMult_Idle.
  - Winner = first set iReq bit scanning from pointer upward, wrapping mod N_REQ.
  - At that edge: latch winner's A/B into oMult_A/B; owner <= winner; pointer <= (winner+1) mod N_REQ; oGrant[winner] <= 1; go to ISSUE.
  - If iMult_Idle=0: no grant, stay in IDLE.
- ISSUE:
  - oMult_Valid=1.
  - Stay until iMult_Idle is sampled 0 (multiplier has left IDLE); then oMult_Valid <= 0, watchdog <= 0, go to WAIT.
- WAIT:
  - Watchdog increments every cycle.
  - On iMult_Done=1: oResult <= iMult_Result; oResultId <= owner; oResultValid pulse; oMult_Ack <= 1; go to DRAIN.
  - If the watchdog reaches TIMEOUT-1 without done: oError pulse; oErrorId <= owner; oMult_Ack <= 1; go to DRAIN. No oResultValid for the aborted job.
  - Done and timeout in the same cycle: done wins.
- DRAIN:
  - oMult_Ack held at 1 until iMult_Idle is sampled 1; then oMult_Ack <= 0, go to IDLE.
  - The next grant is possible at the first IDLE edge, so there is no bubble beyond DRAIN.
- Grant latency: iReq sampled at edge k with the arbiter in IDLE and the multiplier idle gives oGrant high during cycle k+1.
- Result latency: oResultValid rises one cycle after the first iMult_Done=1 sample.
- Requests and pointer:
  - Requests arriving while busy are not granted; the requester keeps iReq high.
  - A requester that drops iReq before its grant is simply skipped.
  - Only the grant winner moves the pointer.
- Arithmetic: oResult is passed through unmodified (low WIDTH bits of the product); no width extension or saturation.
- oMult_A/B stay constant from grant to return to IDLE. The multiplier reloads operands during its IDLE state and first MULT cycle, so this hold is required.

Test Plan:
- Single request: iReq=4'b0001, A=7, B=6 -> oGrant=0001 one cycle; oMult_Valid high until iMult_Idle=0; oResultValid pulse with oResult=42, oResultId=0; oMult_Ack deasserts once the multiplier is idle.
- Fairness: iReq=4'b1111 held, operands A=i+1, B=10 -> grants in order 0,1,2,3,0; results 10,20,30,40 with matching IDs; no overlap of jobs.
- Pointer wrap and skip: pointer=3, iReq=4'b0101 -> grant 0, then 2. After 2 is granted, iReq[0] is dropped before the next IDLE -> no further grant.
- Watchdog: stub multiplier never raises done, TIMEOUT=64 -> oError pulse exactly 64 cycles after WAIT entry, oErrorId=owner, no oResultValid, then oMult_Ack until idle, then back to IDLE.
- Edge cases:
  - A=0xFFFFFFFF, B=2 -> oResult=0xFFFFFFFE (truncated).
  - Done and timeout coincident -> oResultValid, no oError.
- Async reset: assert Reset=0 mid-WAIT between clock edges -> all outputs 0 immediately; after release, the first grant goes to requester 0 when iReq=4'b1111.

Source files
------------

// File: rtl/mult_arbiter.sv
`timescale 1ns/1ps
// mult_arbiter: round-robin front end that shares one sequential multiplier
// between N_REQ requesters. It captures the winning operand pair, runs the
// multiplier's valid/acknowledge handshake, returns the product tagged with
// the owner's ID, and aborts a job whose multiplier never reports done.
//
// Handshakes:
//  - Requester side: iReq[i] is held high with stable operands until oGrant[i]
//    pulses for one cycle; that pulse means the operands were captured.
//  - Multiplier side: oMult_Valid is raised with the operands and dropped once
//    iMult_Idle is seen low (job accepted). After the result (or an abort),
//    oMult_Ack is held high until iMult_Idle is seen high again (job retired).
module mult_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64,
  localparam int IDW    = $clog2(N_REQ)
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [N_REQ-1:0]       iReq,
  input  logic [N_REQ*WIDTH-1:0] iData_A,
  input  logic [N_REQ*WIDTH-1:0] iData_B,
  output logic [N_REQ-1:0]       oGrant,
  output logic [WIDTH-1:0]       oResult,
  output logic                   oResultValid,
  output logic [IDW-1:0]         oResultId,
  output logic                   oError,
  output logic [IDW-1:0]         oErrorId,
  output logic                   oBusy,
  output logic [WIDTH-1:0]       oMult_A,
  output logic [WIDTH-1:0]       oMult_B,
  output logic                   oMult_Valid,
  output logic                   oMult_Ack,
  input  logic                   iMult_Done,
  input  logic                   iMult_Idle,
  input  logic [WIDTH-1:0]       iMult_Result,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // One extra bit keeps the terminal count representable for any TIMEOUT.
  localparam int WDW = $clog2(TIMEOUT) + 1;

  state_t         state;
  state_t         state_nx;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] win_idx;
  logic           win_found;
  logic [WDW-1:0] wd;
  logic           wd_expired;

  logic grant_fire;
  logic issue_exit;
  logic done_fire;
  logic abort_fire;
  logic drain_exit;

  assign dbg_state = state;

  // Round-robin pick: first asserted request at or above the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = 0; off < N_REQ; off++) begin
      if (!win_found && iReq[(int'(ptr) + off) % N_REQ]) begin
        win_found = 1'b1;
        win_idx   = IDW'((int'(ptr) + off) % N_REQ);
      end
    end
  end

  // Event strobes; done beats the watchdog when both land on the same edge.
  assign wd_expired = (wd == WDW'(TIMEOUT - 1));
  assign grant_fire = (state == ST_IDLE)  && win_found && iMult_Idle;
  assign issue_exit = (state == ST_ISSUE) && !iMult_Idle;
  assign done_fire  = (state == ST_WAIT)  && iMult_Done;
  assign abort_fire = (state == ST_WAIT)  && !iMult_Done && wd_expired;
  assign drain_exit = (state == ST_DRAIN) && iMult_Idle;

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (grant_fire)              state_nx = ST_ISSUE;
      ST_ISSUE: if (issue_exit)              state_nx = ST_WAIT;
      ST_WAIT:  if (done_fire || abort_fire) state_nx = ST_DRAIN;
      ST_DRAIN: if (drain_exit)              state_nx = ST_IDLE;
      default:                               state_nx = ST_IDLE;
    endcase
  end

  // Arbitration bookkeeping: only a grant moves the pointer and the owner.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ptr   <= '0;
      owner <= '0;
    end else if (grant_fire) begin
      owner <= win_idx;
      ptr   <= (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Watchdog: cleared as the job is accepted, counts every cycle in WAIT.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wd <= '0;
    end else if (issue_exit) begin
      wd <= '0;
    end else if (state == ST_WAIT) begin
      wd <= wd + 1'b1;
    end
  end

  // Registered outputs: pulses, operand hold, multiplier handshake, results.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oGrant       <= '0;
      oResult      <= '0;
      oResultValid <= 1'b0;
      oResultId    <= '0;
      oError       <= 1'b0;
      oErrorId     <= '0;
      oBusy        <= 1'b0;
      oMult_A      <= '0;
      oMult_B      <= '0;
      oMult_Valid  <= 1'b0;
      oMult_Ack    <= 1'b0;
    end else begin
      oGrant       <= grant_fire ? (N_REQ'(1) << win_idx) : '0;
      oResultValid <= done_fire;
      oError       <= abort_fire;
      oBusy        <= (state_nx != ST_IDLE);
      // Operands stay put until the next grant; the multiplier reloads them
      // while idle and in its first cycle of work.
      if (grant_fire) begin
        oMult_A     <= iData_A[int'(win_idx)*WIDTH +: WIDTH];
        oMult_B     <= iData_B[int'(win_idx)*WIDTH +: WIDTH];
        oMult_Valid <= 1'b1;
      end
      if (issue_exit) begin
        oMult_Valid <= 1'b0;
      end
      if (done_fire) begin
        oResult   <= iMult_Result;
        oResultId <= owner;
      end
      if (abort_fire) begin
        oErrorId <= owner;
      end
      if (done_fire || abort_fire) begin
        oMult_Ack <= 1'b1;
      end
      if (drain_exit) begin
        oMult_Ack <= 1'b0;
      end
    end
  end

endmodule
